subbytes_ced_pipe: RTL and testbench
====================================

// Module: subbytes_ced_pipe
// PURPOSE
//  Multi-lane pipelined AES SubBytes with quadratic concurrent error detection (CED).
//  Each lane carries three pieces of logic:
//   - a main S-box,
//   - an independent predictor (second S-box feeding FFMul_K4_Q2),
//   - a checker that recomputes hi*lo in GF(2^4) on the main result.
//  Adds a valid/ready handshake, per-lane error flags, a sticky error and a saturating error counter.
//  Sits between the AES round datapath and the fault-monitor logic.
// PARAMETERS
//  LANES   4   bytes processed per beat (1..16)
//  CNT_W   8   width of the error-beat counter
//  FI_EN   1   1 = fi_mask port is active; 0 = fi_mask is ignored (tied to 0 internally)
// PORTS
//  clk           in   1         rising-edge clock
//  rst           in   1         synchronous, active-high reset
//  in_valid      in   1         input beat valid
//  in_ready      out  1         block can accept a beat
//  in_data       in   8*LANES   input bytes, lane i = [8i+7:8i]
//  fi_mask       in   8*LANES   fault-injection XOR mask on the main S-box output; sampled with the beat
//  chk_en        in   1         0 = suppress error reporting (flags forced to 0); sampled with the beat
//  out_valid     out  1         output beat valid
//  out_ready     in   1         downstream accepts the beat
//  out_data      out  8*LANES   SubBytes result, including any injected fault
//  out_err_lane  out  LANES     per-lane mismatch for the current output beat
//  err_sticky    out  1         set by any accepted beat with an error; held until clr_err or rst
//  err_count     out  CNT_W     number of accepted beats with >=1 lane error; saturates at all-ones
//  clr_err       in   1         clears err_sticky and err_count
// BEHAVIOUR
//  - Reset values: in_ready=0 during rst, then 1. out_valid=0, out_data=0, out_err_lane=0, err_sticky=0, err_count=0.
//    Reset mid-operation drops every in-flight beat.
//  - Pipeline: 2 stages (S1, S2); each holds one beat plus a valid bit. Latency from input accept to out_valid is 2 cycles when there is no stall.
//  - S1 registers, per lane:
//      m = SB(in) ^ (FI_EN ? fi_mask : 0)
//      w = FFMul(SBp(in)[7:4], SBp(in)[3:0])   (SBp is the predictor S-box)
//    plus chk_en.
//  - S2 registers m as out_data and err_i = chk_en & (FFMul(m[7:4], m[3:0]) != w).
//  - Advance rules:
//      S2 loads when !s2_v | out_ready.
//      S1 loads when !s1_v | S2 loads.
//      in_ready = !s1_v | S2 loads (combinational).
//    Full throughput is 1 beat per cycle; a bubble-free stall holds all data stable.
//  - Handshake: out_data and out_err_lane stay stable while out_valid & !out_ready. A beat is consumed on out_valid & out_ready.
//  - Accounting happens only at consumption, when |out_err_lane:
//      err_sticky <= 1
//      err_count  <= err_count + 1, unless it is all-ones (saturate, no wrap)
//  - clr_err has priority: if it coincides with an erroring consumption, both counters clear and that beat's error is not counted. out_err_lane still shows the error.
//  - chk_en=0 beats never set flags or the counters, even if fi_mask != 0.
//  - Known blind spot, required as-is: a fault that keeps hi*lo unchanged is not detected.
//    Example: m=0x00 -> 0x01 gives 0*1 = 0.
// STRUCTURE
//  - Package subbytes_ced_pkg holds: BYTE_W=8, NIB_W=4, typedef byte_t, typedef nib_t.
//  - Sub-module subbytes_ced_lane is combinational, one per lane (generate loop). It instantiates SubBytes x2 and FFMul_K4_Q2 x2.
//    Outputs: m, w for S1; the mismatch compare for S2 (the checker multiply runs on the registered m).
//  - The top level owns the pipeline registers, the handshake and the error accounting.
// TESTING
//  1. LANES=4, in_data=0x00_53_52_00, fi_mask=0, chk_en=1, out_ready=1 -> after 2 cycles out_data=0x63_ED_00_63, out_err_lane=0, err_count=0.
//  2. Same beat with fi_mask lane0=0x01 -> lane0 out=0x62, out_err_lane=4'b0001, err_sticky=1, err_count=1 after consumption.
//  3. in_data lane1=0x52 (SB=0x00), fi_mask lane1=0x01 -> out lane1=0x01, out_err_lane=0 (blind spot confirmed), err_count unchanged.
//  4. Stream 6 beats with out_ready low for cycles 3-5 -> in_ready low once S1 and S2 are full. No beat is lost or duplicated; output order is preserved; out_data stays stable while stalled.
//  5. CNT_W=2, 5 erroring beats -> err_count = 3 (saturated). Then clr_err in the same cycle as an erroring consumption -> err_count=0, err_sticky=0.
//  6. Beats in flight in S1 and S2, rst pulsed 1 cycle -> next cycle out_valid=0 and all flags/counters 0. The first post-reset beat appears 2 cycles after acceptance. chk_en=0 plus a fault -> no flag.

Source files
------------

// File: rtl/subbytes_ced_pkg.sv
// Shared widths, types and GF arithmetic helpers for the SubBytes CED pipeline.
`default_nettype none
package subbytes_ced_pkg;
  localparam int BYTE_W = 8;
  localparam int NIB_W  = 4;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [NIB_W-1:0]  nib_t;

  localparam byte_t SBOX_AFF_C = 8'h63;

  function automatic byte_t gf8_mul(byte_t a, byte_t b);
    byte_t p;
    byte_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < BYTE_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[BYTE_W-2:0], 1'b0} ^ (aa[BYTE_W-1] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254, then the AES affine transform.
  function automatic byte_t sbox(byte_t x);
    byte_t inv;
    byte_t sq;
    byte_t s;
    inv = 8'h01;
    sq  = x;
    for (int i = 0; i < BYTE_W; i++) begin
      if (i != 0) inv = gf8_mul(inv, sq);
      sq = gf8_mul(sq, sq);
    end
    s = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
           ^ inv[(i + 7) % 8] ^ SBOX_AFF_C[i];
    end
    return s;
  endfunction

  // GF(2^4) multiply modulo x^4 + x + 1.
  function automatic nib_t gf4_mul(nib_t a, nib_t b);
    nib_t p;
    nib_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < NIB_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[NIB_W-2:0], 1'b0} ^ (aa[NIB_W-1] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction
endpackage
`default_nettype wire

// File: rtl/subbytes_ced_lane.sv
// One combinational CED lane: main S-box, independent predictor, and checker multiply.
`default_nettype none
module subbytes_ced_lane
  import subbytes_ced_pkg::*;
(
  input  logic [BYTE_W-1:0] in_b_i,
  input  logic [BYTE_W-1:0] fi_b_i,
  input  logic [BYTE_W-1:0] m_q_i,
  input  logic [NIB_W-1:0]  w_q_i,
  output logic [BYTE_W-1:0] m_o,
  output logic [NIB_W-1:0]  w_o,
  output logic              mism_o
);
  byte_t sb_main;
  byte_t sb_pred;

  always_comb begin
    sb_main = sbox(in_b_i);
    sb_pred = sbox(in_b_i);
    m_o     = sb_main ^ fi_b_i;
    w_o     = gf4_mul(sb_pred[7:4], sb_pred[3:0]);
    // Checker runs on the registered main result, not on the predictor path.
    mism_o  = (gf4_mul(m_q_i[7:4], m_q_i[3:0]) != w_q_i);
  end
endmodule
`default_nettype wire

// File: rtl/subbytes_ced_pipe.sv
// Multi-lane 2-stage pipelined AES SubBytes with quadratic CED, handshake and error accounting.
`default_nettype none
module subbytes_ced_pipe
  import subbytes_ced_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 8,
  parameter int FI_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BYTE_W*LANES-1:0] in_data,
  input  logic [BYTE_W*LANES-1:0] fi_mask,
  input  logic                    chk_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BYTE_W*LANES-1:0] out_data,
  output logic [LANES-1:0]        out_err_lane,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        err_count,
  input  logic                    clr_err
);
  logic [BYTE_W*LANES-1:0] fi_eff;
  logic [BYTE_W*LANES-1:0] m_d;
  logic [NIB_W*LANES-1:0]  w_d;
  logic [LANES-1:0]        mism;
  logic [LANES-1:0]        err_d;

  logic                    s1_v_q;
  logic [BYTE_W*LANES-1:0] s1_m_q;
  logic [NIB_W*LANES-1:0]  s1_w_q;
  logic                    s1_chk_q;
  logic                    s2_v_q;
  logic [BYTE_W*LANES-1:0] s2_data_q;
  logic [LANES-1:0]        s2_err_q;
  logic                    err_sticky_q;
  logic [CNT_W-1:0]        err_cnt_q;

  logic s2_load;
  logic s1_load;
  logic consume;

  assign fi_eff = (FI_EN != 0) ? fi_mask : '0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    subbytes_ced_lane u_lane (
      .in_b_i (in_data[BYTE_W*g +: BYTE_W]),
      .fi_b_i (fi_eff[BYTE_W*g +: BYTE_W]),
      .m_q_i  (s1_m_q[BYTE_W*g +: BYTE_W]),
      .w_q_i  (s1_w_q[NIB_W*g +: NIB_W]),
      .m_o    (m_d[BYTE_W*g +: BYTE_W]),
      .w_o    (w_d[NIB_W*g +: NIB_W]),
      .mism_o (mism[g])
    );
  end

  assign s2_load = !s2_v_q || out_ready;
  assign s1_load = !s1_v_q || s2_load;
  assign in_ready = !rst && s1_load;
  assign consume  = s2_v_q && out_ready;
  assign err_d    = s1_chk_q ? mism : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q       <= 1'b0;
      s1_m_q       <= '0;
      s1_w_q       <= '0;
      s1_chk_q     <= 1'b0;
      s2_v_q       <= 1'b0;
      s2_data_q    <= '0;
      s2_err_q     <= '0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      if (s1_load) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_m_q   <= m_d;
          s1_w_q   <= w_d;
          s1_chk_q <= chk_en;
        end
      end
      if (s2_load) begin
        s2_v_q   <= s1_v_q;
        s2_err_q <= s1_v_q ? err_d : '0;
        if (s1_v_q) s2_data_q <= s1_m_q;
      end
      // Clear wins over a coincident erroring consumption.
      if (clr_err) begin
        err_sticky_q <= 1'b0;
        err_cnt_q    <= '0;
      end else if (consume && (|s2_err_q)) begin
        err_sticky_q <= 1'b1;
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid    = s2_v_q;
  assign out_data     = s2_data_q;
  assign out_err_lane = s2_err_q;
  assign err_sticky   = err_sticky_q;
  assign err_count    = err_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_subbytes_ced_pipe.sv
`default_nettype none
module tb_subbytes_ced_pipe;
  localparam int LANES   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_data = 0;
  logic [31:0] fi_mask = 0;
  logic        chk_en = 1;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_data;
  logic [3:0]  out_err_lane;
  logic        err_sticky;
  logic [CNT_W-1:0] err_count;
  logic        clr_err = 0;

  int total = 0;
  int bad = 0;
  logic [7:0] sb_tab [0:255];
  int exp_cnt;
  logic exp_sticky;

  always #5 clk = ~clk;

  subbytes_ced_pipe #(.LANES(LANES), .CNT_W(CNT_W), .FI_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fi_mask(fi_mask), .chk_en(chk_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_lane(out_err_lane), .err_sticky(err_sticky),
    .err_count(err_count), .clr_err(clr_err)
  );

  // Reference arithmetic: long-division reduction of carry-less products.
  function automatic logic [7:0] ref_gmul(logic [7:0] a, logic [7:0] b);
    logic [15:0] p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h11B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [3:0] ref_gf4(logic [3:0] a, logic [3:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int k = 7; k >= 4; k--) if (p[k]) p = p ^ (8'h13 << (k - 4));
    return p[3:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [15:0] dd, t;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (ref_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      dd = {inv, inv};
      s = inv ^ 8'h63;
      for (int k = 1; k <= 4; k++) begin
        t = dd >> (8 - k);
        s = s ^ t[7:0];
      end
      sb_tab[x] = s;
    end
  endtask

  task automatic model_beat(input logic [31:0] d, input logic [31:0] f, input logic c,
                            output logic [31:0] od, output logic [3:0] oe);
    logic [7:0] s, m;
    logic [3:0] w;
    for (int i = 0; i < LANES; i++) begin
      s = sb_tab[d[8*i +: 8]];
      m = s ^ f[8*i +: 8];
      w = ref_gf4(s[7:4], s[3:0]);
      od[8*i +: 8] = m;
      oe[i] = c && (ref_gf4(m[7:4], m[3:0]) != w);
    end
  endtask

  // Pushes one beat with out_ready high and returns what came out plus its latency.
  task automatic xfer(input logic [31:0] d, input logic [31:0] f, input logic c, input logic clr_c,
                      output logic [31:0] od, output logic [3:0] oe, output int lat);
    int guard;
    in_data = d; fi_mask = f; chk_en = c; in_valid = 1; out_ready = 1;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 0; fi_mask = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 10);
    od = out_data; oe = out_err_lane;
    if (clr_c) clr_err = 1;
    @(posedge clk); #1;
    clr_err = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (out_err_lane !== 4'h0 || err_sticky !== 1'b0 || err_count !== '0) begin
      bad++; $display("FAIL reset_flags got err=%b sticky=%0b cnt=%0d exp=0", out_err_lane, err_sticky, err_count);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [31:0] od; logic [3:0] oe; int lat;
    xfer(32'h00535200, 32'h0, 1'b1, 1'b0, od, oe, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL vec1_latency got=%0d exp=2", lat); end
    total++; if (od !== 32'h63ED0063) begin bad++; $display("FAIL vec1_data got=%h exp=63ed0063", od); end
    total++; if (oe !== 4'b0000 || err_count !== 2'd0) begin bad++; $display("FAIL vec1_err got=%b cnt=%0d exp=0000 cnt=0", oe, err_count); end
    xfer(32'h00535200, 32'h00000001, 1'b1, 1'b0, od, oe, lat);
    total++; if (od !== 32'h63ED0062) begin bad++; $display("FAIL vec2_data got=%h exp=63ed0062", od); end
    total++; if (oe !== 4'b0001) begin bad++; $display("FAIL vec2_err got=%b exp=0001", oe); end
    total++; if (err_sticky !== 1'b1 || err_count !== 2'd1) begin bad++; $display("FAIL vec2_acct got sticky=%0b cnt=%0d exp sticky=1 cnt=1", err_sticky, err_count); end
    xfer(32'h00535200, 32'h00000100, 1'b1, 1'b0, od, oe, lat);
    total++; if (od !== 32'h63ED0163) begin bad++; $display("FAIL vec3_data got=%h exp=63ed0163", od); end
    total++; if (oe !== 4'b0000 || err_count !== 2'd1) begin bad++; $display("FAIL vec3_blindspot got err=%b cnt=%0d exp=0000 cnt=1", oe, err_count); end
  endtask

  task automatic test_random();
    logic [31:0] d, f, od, xd; logic [3:0] oe, xe; logic c; int lat;
    clr_err = 1; @(posedge clk); #1 clr_err = 0;
    exp_cnt = 0; exp_sticky = 0;
    for (int n = 0; n < 40; n++) begin
      d = $urandom;
      case ($urandom_range(0, 2))
        0: f = 0;
        1: f = 32'(1) << $urandom_range(0, 31);
        default: f = $urandom;
      endcase
      c = ($urandom_range(0, 3) != 0);
      model_beat(d, f, c, xd, xe);
      xfer(d, f, c, 1'b0, od, oe, lat);
      if (xe != 0) begin exp_sticky = 1; if (exp_cnt < CNT_MAX) exp_cnt++; end
      total++; if (od !== xd || oe !== xe || lat != 2) begin
        bad++; $display("FAIL rand_beat%0d got data=%h err=%b lat=%0d exp data=%h err=%b lat=2", n, od, oe, lat, xd, xe);
      end
      total++; if (err_count !== CNT_W'(exp_cnt) || err_sticky !== exp_sticky) begin
        bad++; $display("FAIL rand_acct%0d got cnt=%0d sticky=%0b exp cnt=%0d sticky=%0b", n, err_count, err_sticky, exp_cnt, exp_sticky);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] od; logic [3:0] oe; int lat;
    clr_err = 1; @(posedge clk); #1 clr_err = 0;
    total++; if (err_count !== 2'd0 || err_sticky !== 1'b0) begin bad++; $display("FAIL clr_err got cnt=%0d sticky=%0b exp 0", err_count, err_sticky); end
    for (int n = 0; n < 5; n++) xfer($urandom & 32'hFFFFFF00, 32'h00000001, 1'b1, 1'b0, od, oe, lat);
    total++; if (err_count !== 2'd3 || err_sticky !== 1'b1) begin bad++; $display("FAIL saturate got cnt=%0d sticky=%0b exp cnt=3 sticky=1", err_count, err_sticky); end
    xfer(32'h0, 32'h00000001, 1'b1, 1'b1, od, oe, lat);
    total++; if (oe !== 4'b0001) begin bad++; $display("FAIL clr_coincide_lane got=%b exp=0001", oe); end
    total++; if (err_count !== 2'd0 || err_sticky !== 1'b0) begin bad++; $display("FAIL clr_priority got cnt=%0d sticky=%0b exp 0", err_count, err_sticky); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] beats [6];
    logic [31:0] xq [$];
    logic [31:0] xd, held; logic [3:0] xe;
    int idx = 0, got = 0;
    logic stalled_prev = 0, saw_block = 0;
    for (int i = 0; i < 6; i++) beats[i] = $urandom;
    chk_en = 1; fi_mask = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid  = (idx < 6);
      in_data   = (idx < 6) ? beats[idx] : 32'h0;
      out_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (stalled_prev) begin
        total++; if (out_data !== held) begin bad++; $display("FAIL stall_stable got=%h exp=%h", out_data, held); end
      end
      if (in_valid && !in_ready) saw_block = 1;
      if (in_valid && in_ready) begin
        model_beat(beats[idx], 32'h0, 1'b1, xd, xe);
        xq.push_back(xd); idx++;
      end
      if (out_valid && out_ready) begin
        xd = (xq.size() > 0) ? xq.pop_front() : 32'hxxxxxxxx;
        total++; if (out_data !== xd) begin bad++; $display("FAIL stream_beat%0d got=%h exp=%h", got, out_data, xd); end
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      held = out_data;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    total++; if (got != 6 || xq.size() != 0) begin bad++; $display("FAIL stream_count got=%0d pending=%0d exp=6/0", got, xq.size()); end
    total++; if (saw_block !== 1'b1) begin bad++; $display("FAIL stream_backpressure got in_ready_low=%0b exp=1", saw_block); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] od, xd; logic [3:0] oe, xe; int lat;
    xfer(32'h0, 32'h00000001, 1'b1, 1'b0, od, oe, lat);
    out_ready = 0; in_valid = 1; in_data = 32'h0; fi_mask = 32'h01010101; chk_en = 1;
    repeat (2) @(posedge clk);
    #1 in_valid = 0; fi_mask = 0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || err_sticky !== 1'b1) begin bad++; $display("FAIL midflight_fill got valid=%0b sticky=%0b exp 1/1", out_valid, err_sticky); end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err_lane !== 4'h0) begin
      bad++; $display("FAIL midflight_reset_out got valid=%0b data=%h err=%b exp 0", out_valid, out_data, out_err_lane);
    end
    total++; if (err_sticky !== 1'b0 || err_count !== '0) begin bad++; $display("FAIL midflight_reset_acct got sticky=%0b cnt=%0d exp 0", err_sticky, err_count); end
    @(posedge clk); #1;
    model_beat(32'h00535200, 32'h00000001, 1'b0, xd, xe);
    xfer(32'h00535200, 32'h00000001, 1'b0, 1'b0, od, oe, lat);
    total++; if (lat != 2 || od !== xd) begin bad++; $display("FAIL post_reset_beat got lat=%0d data=%h exp lat=2 data=%h", lat, od, xd); end
    total++; if (oe !== 4'b0000 || err_count !== '0 || err_sticky !== 1'b0) begin
      bad++; $display("FAIL chk_off_fault got err=%b cnt=%0d sticky=%0b exp 0", oe, err_count, err_sticky);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vectors();
    test_random();
    test_saturation();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
